isp_1bit_erosion: RTL and testbench
===================================

// Module: isp_1bit_erosion
// PURPOSE
// - 3x3 binary erosion for the 1-bit ISP path: output 1 only if all 9 window pixels are 1.
// - Dual of the dilation stage; paired with it for open/close filtering between binarisation and SDRAM write.
// - Self-contained: owns its line buffers, row/column tracking, frame-border padding and end-of-frame flush.
// PARAMETERS
// - IMG_W       640   pixels per line (>=4)
// - IMG_H       480   lines per frame (>=3)
// - BORDER_VAL  1'b0  value substituted for out-of-frame window taps (0 erodes the border, 1 preserves it)
// PORTS
// - sys_clk        in   1   single clock, all logic rising-edge
// - sys_rst        in   1   asynchronous, active-high reset
// - frame_start    in   1   1-cycle pulse before first pixel of a frame; clears counters, aborts any flush
// - wr_en          in   1   input pixel strobe, raster order, gaps allowed
// - img_1bit_in    in   1   binary pixel, valid when wr_en=1
// - erosion_wr_en  out  1   output pixel strobe
// - img_1bit_out   out  1   eroded pixel; forced 0 when erosion_wr_en=0
// - erosion_data   out  16  16'hFFFF if img_1bit_out=1 else 16'h0000 (RGB565 white/black)
// - frame_done     out  1   1-cycle pulse coincident with the last output pixel (IMG_W*IMG_H-th)
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, counters 0, line buffers not cleared (contents masked by FSM).
// - FSM: IDLE -frame_start-> FILL; FILL -(IMG_W+1 input strobes)-> RUN;
//   RUN -(last input pixel, index IMG_W*IMG_H-1)-> FLUSH; FLUSH -(IMG_W+1 internal strobes)-> IDLE.
//   frame_start in any state -> FILL with counters cleared; pending outputs of the old frame are dropped.
// - wr_en in IDLE ignored; wr_en in FLUSH ignored (protocol violation, flush continues unaffected).
// - Pixel strobe s = wr_en (FILL/RUN) or internal 1-per-cycle flush tick (FLUSH, feeds BORDER_VAL).
// - Each s shifts the window: two line buffers of IMG_W bits + 3x3 register window.
// - Output (r,c) is computed on the strobe for input index r*IMG_W+c+IMG_W+1; FILL emits nothing.
// - Border mask from output counters: row 0 masks top taps, row IMG_H-1 bottom, col 0 left,
//   col IMG_W-1 right; masked taps take BORDER_VAL (corners mask both).
// - Pipeline: stage 1 = three row-ANDs, stage 2 = AND of the three; erosion_wr_en = s delayed 2 cycles.
// - Latency: 2 sys_clk after the producing strobe; throughput 1 pixel/cycle; no back-pressure.
// - Output counters: col wraps IMG_W-1 -> 0 incrementing row; frame_done when row=IMG_H-1, col=IMG_W-1.
// - Counter widths $clog2(IMG_W), $clog2(IMG_H); no overflow past frame end (FSM leaves RUN first).
// - Simultaneous frame_start and wr_en: frame_start wins, that wr_en pixel is pixel 0 of the new frame.
// - Reset mid-frame: outputs drop to 0 asynchronously; next frame needs frame_start.
// STRUCTURE
// - Shared include isp_defs.vh: erosion FSM state encodings, RGB565 WHITE/BLACK 16-bit constants.
// - Sub-module isp_1bit_line_buf: IMG_W-deep 1-bit shift buffer, shift-enable input, two tap outputs
//   (1 and 2 lines delayed); reused by the dilation stage when it is refactored.
// - Top holds FSM, input/output counters, border mask, 2-stage AND tree, strobe delay, data expansion.
// TESTING (sim with IMG_W=8, IMG_H=6)
// - All-ones frame, BORDER_VAL=0 -> 48 outputs; rows 1-4 cols 1-6 =1, border ring =0; frame_done on 48th.
// - All-ones frame, BORDER_VAL=1 -> all 48 outputs 1, erosion_data=16'hFFFF each.
// - All-ones, single 0 at (2,3), BORDER_VAL=1 -> zeros exactly at rows 1-3, cols 2-4 (9 px), else 1.
// - Test 1 with wr_en every other cycle -> identical output sequence, each 2 cycles after its strobe.
// - sys_rst pulsed after input pixel 20 -> outputs 0 immediately; frame_start + new frame -> test 1 result.
// - frame_start during FLUSH -> remaining flush outputs absent, no frame_done, next frame correct.

Source files
------------

// File: rtl/isp_1bit_erosion_pkg.sv
// Shared definitions for the 1-bit ISP erosion stage: FSM state encodings
// and the RGB565 constants used to expand a binary pixel for SDRAM write.
package isp_1bit_erosion_pkg;

  // Frame sequencing states of the erosion stage
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } erosion_state_t;

  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  // Binary pixel to RGB565 white/black
  function automatic logic [15:0] expand_pixel(input logic pix);
    return pix ? RGB565_WHITE : RGB565_BLACK;
  endfunction

endpackage

// File: rtl/isp_1bit_line_buf.sv
// Two cascaded DEPTH-bit shift lines for a 1-bit raster stream.
// With din being pixel n, tap1 presents pixel n-DEPTH and tap2 pixel n-2*DEPTH.
// Contents are deliberately not reset; the owner masks stale data.
module isp_1bit_line_buf #(
  parameter int DEPTH = 640
) (
  input  logic clk,
  input  logic shift_en,
  input  logic din,
  output logic tap1,
  output logic tap2
);

  logic [DEPTH-1:0] line1_q;
  logic [DEPTH-1:0] line1_d;
  logic [DEPTH-1:0] line2_q;
  logic [DEPTH-1:0] line2_d;

  // Shift both lines by one pixel on each enabled strobe
  always_comb begin
    line1_d = line1_q;
    line2_d = line2_q;
    if (shift_en) begin
      line1_d = {line1_q[DEPTH-2:0], din};
      line2_d = {line2_q[DEPTH-2:0], line1_q[DEPTH-1]};
    end
  end

  // Line storage, no reset so it can map onto plain shift cells
  always_ff @(posedge clk) begin
    line1_q <= line1_d;
    line2_q <= line2_d;
  end

  assign tap1 = line1_q[DEPTH-1];
  assign tap2 = line2_q[DEPTH-1];

endmodule

// File: rtl/isp_1bit_erosion.sv
// 3x3 binary erosion for the 1-bit ISP path. Owns its line buffers,
// input/output position tracking, frame-border padding and the
// end-of-frame flush that pushes out the last line and a pixel.
module isp_1bit_erosion
  import isp_1bit_erosion_pkg::*;
#(
  parameter int   IMG_W      = 640,
  parameter int   IMG_H      = 480,
  parameter logic BORDER_VAL = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        frame_start,
  input  logic        wr_en,
  input  logic        img_1bit_in,
  output logic        erosion_wr_en,
  output logic        img_1bit_out,
  output logic [15:0] erosion_data,
  output logic        frame_done
);

  localparam int PIX_N = IMG_W * IMG_H;
  localparam int IN_W  = $clog2(PIX_N + 1);
  localparam int FL_W  = $clog2(IMG_W + 1);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [IN_W-1:0]  FILL_LAST  = IN_W'(IMG_W);
  localparam logic [IN_W-1:0]  PIX_LAST   = IN_W'(PIX_N - 1);
  localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H - 1);

  erosion_state_t state_q, state_d;

  logic [IN_W-1:0]  in_cnt_q, in_cnt_d;
  logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;

  logic [2:0] top_q, top_d;
  logic [2:0] mid_q, mid_d;
  logic [2:0] bot_q, bot_d;
  logic [2:0] top_m, mid_m, bot_m;

  logic [2:0] row_and_q, row_and_d;
  logic       valid1_q, valid1_d;
  logic       last1_q, last1_d;
  logic       pix2_q, pix2_d;
  logic       valid2_q, valid2_d;
  logic       done2_q, done2_d;

  logic accept_in;
  logic flushing;
  logic emitting;
  logic in_strobe;
  logic flush_tick;
  logic strobe;
  logic pix_in;
  logic produce;
  logic tap1;
  logic tap2;

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state: frame_start restarts from any state, otherwise count strobes
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = ST_FILL;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_FILL:  if (in_strobe && in_cnt_q == FILL_LAST) state_d = ST_RUN;
        ST_RUN:   if (in_strobe && in_cnt_q == PIX_LAST)  state_d = ST_FLUSH;
        ST_FLUSH: if (flush_tick && flush_cnt_q == FLUSH_LAST) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State decode: which states take input pixels, flush, and emit results
  always_comb begin
    accept_in = 1'b0;
    flushing  = 1'b0;
    emitting  = 1'b0;
    unique case (state_q)
      ST_IDLE:  ;
      ST_FILL:  accept_in = 1'b1;
      ST_RUN:   begin accept_in = 1'b1; emitting = 1'b1; end
      ST_FLUSH: begin flushing  = 1'b1; emitting = 1'b1; end
      default:  ;
    endcase
  end

  // Pixel strobe: real pixels while filling/running, padding ticks while flushing
  always_comb begin
    in_strobe  = wr_en && (frame_start || accept_in);
    flush_tick = flushing && !frame_start;
    strobe     = in_strobe || flush_tick;
    pix_in     = flush_tick ? BORDER_VAL : img_1bit_in;
    produce    = strobe && emitting && !frame_start;
  end

  isp_1bit_line_buf #(
    .DEPTH (IMG_W)
  ) u_line_buf (
    .clk      (sys_clk),
    .shift_en (strobe),
    .din      (pix_in),
    .tap1     (tap1),
    .tap2     (tap2)
  );

  // Input and flush counters; a simultaneous pixel becomes pixel 0 of the new frame
  always_comb begin
    in_cnt_d    = in_cnt_q;
    flush_cnt_d = flush_tick ? flush_cnt_q + FL_W'(1) : '0;
    if (frame_start)    in_cnt_d = wr_en ? IN_W'(1) : '0;
    else if (in_strobe) in_cnt_d = in_cnt_q + IN_W'(1);
  end

  // Output position of the pixel produced by the current strobe
  always_comb begin
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    if (frame_start) begin
      out_col_d = '0;
      out_row_d = '0;
    end else if (produce) begin
      if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + ROW_W'(1);
      end else begin
        out_col_d = out_col_q + COL_W'(1);
      end
    end
  end

  // 3x3 window shift; bit 2 is the newest (right) column
  always_comb begin
    top_d = top_q;
    mid_d = mid_q;
    bot_d = bot_q;
    if (strobe) begin
      top_d = {tap2,   top_q[2:1]};
      mid_d = {tap1,   mid_q[2:1]};
      bot_d = {pix_in, bot_q[2:1]};
    end
  end

  // Border padding: out-of-frame taps are replaced by BORDER_VAL
  always_comb begin
    top_m = top_d;
    mid_m = mid_d;
    bot_m = bot_d;
    if (out_row_q == '0)      top_m = {3{BORDER_VAL}};
    if (out_row_q == ROW_LAST) bot_m = {3{BORDER_VAL}};
    if (out_col_q == '0) begin
      top_m[0] = BORDER_VAL;
      mid_m[0] = BORDER_VAL;
      bot_m[0] = BORDER_VAL;
    end
    if (out_col_q == COL_LAST) begin
      top_m[2] = BORDER_VAL;
      mid_m[2] = BORDER_VAL;
      bot_m[2] = BORDER_VAL;
    end
  end

  // Two-stage AND tree; frame_start drops anything still in flight
  always_comb begin
    row_and_d = {&top_m, &mid_m, &bot_m};
    valid1_d  = produce;
    last1_d   = produce && out_row_q == ROW_LAST && out_col_q == COL_LAST;
    pix2_d    = &row_and_q;
    valid2_d  = valid1_q && !frame_start;
    done2_d   = valid1_q && last1_q && !frame_start;
  end

  // Counters, window and pipeline registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      in_cnt_q    <= '0;
      flush_cnt_q <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
      row_and_q   <= '0;
      valid1_q    <= 1'b0;
      last1_q     <= 1'b0;
      pix2_q      <= 1'b0;
      valid2_q    <= 1'b0;
      done2_q     <= 1'b0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
      row_and_q   <= row_and_d;
      valid1_q    <= valid1_d;
      last1_q     <= last1_d;
      pix2_q      <= pix2_d;
      valid2_q    <= valid2_d;
      done2_q     <= done2_d;
    end
  end

  // Output drive; pixel and data are forced low when no strobe is presented
  always_comb begin
    erosion_wr_en = valid2_q;
    img_1bit_out  = valid2_q & pix2_q;
    erosion_data  = expand_pixel(img_1bit_out);
    frame_done    = done2_q;
  end

endmodule

// File: tb/tb_isp_1bit_erosion.sv
// Randomised bench for isp_1bit_erosion (8x6 frames). Two instances share the
// input stream, one padding with 0 and one with 1. A raster-level reference
// erodes the stored frame directly and predicts when each pixel must appear.
module tb_isp_1bit_erosion;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int QD = 256;

  logic sys_clk     = 1'b0;
  logic sys_rst     = 1'b0;
  logic frame_start = 1'b0;
  logic wr_en       = 1'b0;
  logic img_1bit_in = 1'b0;

  logic        ewr0, ewr1, iout0, iout1, fdone0, fdone1;
  logic [15:0] edata0, edata1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit ref_img [N];
  int q_idx [2][QD];
  int q_val [2][QD];
  int q_due [2][QD];
  int q_head [2];
  int q_tail [2];
  bit model_active = 1'b0;
  int model_n      = 0;

  isp_1bit_erosion #(.IMG_W(W), .IMG_H(H), .BORDER_VAL(1'b0)) dut0 (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .frame_start   (frame_start),
    .wr_en         (wr_en),
    .img_1bit_in   (img_1bit_in),
    .erosion_wr_en (ewr0),
    .img_1bit_out  (iout0),
    .erosion_data  (edata0),
    .frame_done    (fdone0)
  );

  isp_1bit_erosion #(.IMG_W(W), .IMG_H(H), .BORDER_VAL(1'b1)) dut1 (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .frame_start   (frame_start),
    .wr_en         (wr_en),
    .img_1bit_in   (img_1bit_in),
    .erosion_wr_en (ewr1),
    .img_1bit_out  (iout1),
    .erosion_data  (edata1),
    .frame_done    (fdone1)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Erosion of raster pixel j with out-of-frame taps equal to b
  function automatic int erode_ref(input bit b, input int j);
    int r = j / W;
    int c = j % W;
    int v = 1;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = r + dr;
        int cc = c + dc;
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) v = v & int'(b);
        else v = v & int'(ref_img[rr * W + cc]);
      end
    end
    return v;
  endfunction

  task automatic push_out(input int j, input int due);
    for (int d = 0; d < 2; d++) begin
      q_idx[d][q_tail[d] % QD] = j;
      q_val[d][q_tail[d] % QD] = erode_ref(d[0], j);
      q_due[d][q_tail[d] % QD] = due;
      q_tail[d]++;
    end
  endtask

  task automatic drop_from(input int q);
    for (int d = 0; d < 2; d++)
      while (q_tail[d] > q_head[d] && q_due[d][(q_tail[d] - 1) % QD] >= q) q_tail[d]--;
  endtask

  // Drive one cycle of inputs and update the reference expectations
  task automatic apply_stimulus(input bit fs, input bit we, input bit px);
    @(negedge sys_clk);
    frame_start = fs;
    wr_en       = we;
    img_1bit_in = px;
    if (fs) begin
      drop_from(cyc + 1);
      model_active = 1'b1;
      model_n      = 0;
    end
    if (we && model_active) begin
      ref_img[model_n] = px;
      if (model_n >= W + 1) push_out(model_n - W - 1, cyc + 2);
      model_n++;
      if (model_n == N) begin
        for (int k = 0; k <= W; k++) push_out(N - W - 1 + k, cyc + 3 + k);
        model_active = 1'b0;
      end
    end
  endtask

  // mode 0 all ones, 1 all ones with a hole at (2,3), 2 random mostly-ones
  task automatic send_frame(input int mode, input int fixed_gap, input int rand_gap,
                            input bit fs_with_first, input int n_pix);
    bit px;
    if (!fs_with_first) apply_stimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n_pix; i++) begin
      int gap = fixed_gap + ((rand_gap > 0) ? int'($urandom_range(0, rand_gap)) : 0);
      if (i > 0)
        for (int g = 0; g < gap; g++) apply_stimulus(1'b0, 1'b0, 1'($urandom));
      case (mode)
        0:       px = 1'b1;
        1:       px = (i != 2 * W + 3);
        default: px = ($urandom_range(0, 99) < 85);
      endcase
      apply_stimulus(fs_with_first && i == 0, 1'b1, px);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (q_tail[0] != q_head[0] || q_tail[1] != q_head[1]); i++)
      apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("drain dut0", q_tail[0] - q_head[0], 0);
    check_output("drain dut1", q_tail[1] - q_head[1], 0);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk);
    sys_rst     = 1'b1;
    frame_start = 1'b0;
    wr_en       = 1'b0;
    for (int d = 0; d < 2; d++) q_tail[d] = q_head[d];
    model_active = 1'b0;
    #1;
    check_output("reset dut0 outputs", {fdone0, ewr0, iout0, edata0}, 0);
    check_output("reset dut1 outputs", {fdone1, ewr1, iout1, edata1}, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic monitor_dut(input int d);
    logic        ewr, iout, fd;
    logic [15:0] ed;
    int          s;
    ewr  = d[0] ? ewr1   : ewr0;
    iout = d[0] ? iout1  : iout0;
    fd   = d[0] ? fdone1 : fdone0;
    ed   = d[0] ? edata1 : edata0;
    if (ewr) begin
      if (q_head[d] == q_tail[d]) begin
        check_output($sformatf("dut%0d unexpected output", d), 1, 0);
      end else begin
        s = q_head[d] % QD;
        check_output($sformatf("dut%0d pixel %0d", d, q_idx[d][s]), iout, q_val[d][s]);
        check_output($sformatf("dut%0d data %0d", d, q_idx[d][s]), ed,
                     (q_val[d][s] != 0) ? 32'hFFFF : 32'h0);
        check_output($sformatf("dut%0d latency %0d", d, q_idx[d][s]), cyc, q_due[d][s]);
        check_output($sformatf("dut%0d frame_done %0d", d, q_idx[d][s]), fd,
                     (q_idx[d][s] == N - 1) ? 1 : 0);
        q_head[d]++;
      end
    end else begin
      check_output($sformatf("dut%0d idle outputs", d), {fd, iout, ed}, 0);
    end
    while (q_head[d] != q_tail[d] && q_due[d][q_head[d] % QD] < cyc) begin
      check_output($sformatf("dut%0d missing pixel %0d", d, q_idx[d][q_head[d] % QD]), 0, 1);
      q_head[d]++;
    end
  endtask

  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      monitor_dut(0);
      monitor_dut(1);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      q_head[d] = 0;
      q_tail[d] = 0;
    end
    #2 sys_rst = 1'b1;
    #1;
    check_output("power-on dut0 outputs", {fdone0, ewr0, iout0, edata0}, 0);
    check_output("power-on dut1 outputs", {fdone1, ewr1, iout1, edata1}, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    $display("[TB] idle wr_en before any frame_start");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 1'b1);

    $display("[TB] all-ones frame, continuous strobes");
    send_frame(0, 0, 0, 1'b0, N);
    wait_drain();

    $display("[TB] all-ones frame with a single zero at (2,3)");
    send_frame(1, 0, 0, 1'b0, N);
    wait_drain();

    $display("[TB] all-ones frame, strobe every other cycle");
    send_frame(0, 1, 0, 1'b0, N);
    wait_drain();

    $display("[TB] reset after input pixel 20");
    send_frame(0, 0, 0, 1'b0, 21);
    pulse_reset();
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 1'b0);
    send_frame(0, 0, 0, 1'b0, N);
    wait_drain();

    $display("[TB] frame_start during flush");
    send_frame(2, 0, 0, 1'b0, N);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
    send_frame(2, 0, 1, 1'b0, N);
    wait_drain();

    $display("[TB] frame_start mid-run, then frame_start with first pixel");
    send_frame(2, 0, 0, 1'b0, 30);
    send_frame(2, 0, 0, 1'b1, N);
    wait_drain();

    $display("[TB] random frames with gaps and wr_en during flush");
    for (int f = 0; f < 4; f++) begin
      send_frame(2, 0, 2, 1'($urandom), N);
      for (int i = 0; i < W + 3; i++) apply_stimulus(1'b0, 1'b1, 1'($urandom));
      wait_drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
